// File: rtl/exhaustive_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : exhaustive_vector_sequencer
// Brief    : Walks every N_IN-bit vector onto a circuit under test, samples its
//            1-bit response after a settle time, and streams records via FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module exhaustive_vector_sequencer #(
    parameter int N_IN       = 5,
    parameter int SETTLE     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            CK,
    input  logic            reset,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            rec_valid,
    input  logic            rec_ready,
    output logic [N_IN-1:0] rec_vec,
    output logic            rec_resp,
    output logic            rec_last,
    output logic [N_IN:0]   ones_count
);

    localparam int c_CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_REC_W = N_IN + 2;

    localparam logic [c_CNT_W-1:0] c_SETTLE_LOAD = c_CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]    c_LAST_VEC    = '1;
    localparam logic [c_PTR_W:0]   c_FULL_COUNT  = (c_PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_load;
    logic                 w_dec;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_last;
    logic                 r_busy;
    logic                 r_done;
    logic [N_IN-1:0]      r_vec;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [N_IN:0]        r_ones;
    logic [c_REC_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic [c_REC_W-1:0]   w_head;

    assign w_full  = (r_count == c_FULL_COUNT);
    assign w_empty = (r_count == '0);
    assign w_last  = (r_vec == c_LAST_VEC);
    assign w_pop   = !w_empty && rec_ready;

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != ST_IDLE);
            r_done  <= (w_next_state == ST_DONE);
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_CAPTURE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_CAPTURE: begin
                // A pop in the same cycle does not make room on a full FIFO.
                if (!w_full) begin
                    w_push       = 1'b1;
                    w_next_state = w_last ? ST_DRAIN : ST_SETTLE;
                end
            end
            ST_DRAIN: begin
                if (w_empty) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_vec  <= '0;
            r_cnt  <= '0;
            r_ones <= '0;
        end else if (w_load) begin
            r_vec  <= '0;
            r_cnt  <= c_SETTLE_LOAD;
            r_ones <= '0;
        end else if (w_dec) begin
            r_cnt <= r_cnt - 1'b1;
        end else if (w_push) begin
            r_ones <= r_ones + {{N_IN{1'b0}}, dut_out};
            if (!w_last) begin
                r_vec <= r_vec + 1'b1;
                r_cnt <= c_SETTLE_LOAD;
            end
        end
    end

    // Storage needs no reset: the cleared count marks every entry invalid.
    always_ff @(posedge CK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_vec, dut_out, w_last};
        end
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign rec_valid  = !w_empty;
    assign rec_vec    = rec_valid ? w_head[c_REC_W-1:2] : '0;
    assign rec_resp   = rec_valid ? w_head[1] : 1'b0;
    assign rec_last   = rec_valid ? w_head[0] : 1'b0;
    assign dut_in     = r_vec;
    assign ones_count = r_ones;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_exhaustive_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_exhaustive_vector_sequencer
// Brief    : Directed bench: parity (SETTLE=1) and AND (SETTLE=3) circuit models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exhaustive_vector_sequencer;

    logic       CK;
    logic       reset;
    logic       start, start3;
    logic [4:0] dut_in, dut_in3;
    logic       dut_out, dut_out3;
    logic       busy, busy3, done, done3;
    logic       rec_valid, rec_valid3;
    logic       rec_ready, rec_ready3;
    logic [4:0] rec_vec, rec_vec3;
    logic       rec_resp, rec_resp3, rec_last, rec_last3;
    logic [5:0] ones_count, ones_count3;

    int         n_vec = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         e0 = 0;
    int         done_cnt = 0, done_at = 0;
    int         done3_cnt = 0, done3_at = 0;
    int         base;
    logic [6:0] recs[$];

    assign dut_out  = ^dut_in;
    assign dut_out3 = &dut_in3;

    exhaustive_vector_sequencer #(.N_IN(5), .SETTLE(1), .FIFO_DEPTH(4)) u_dut (
        .CK(CK), .reset(reset), .start(start), .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_vec(rec_vec), .rec_resp(rec_resp), .rec_last(rec_last),
        .ones_count(ones_count)
    );

    exhaustive_vector_sequencer #(.N_IN(5), .SETTLE(3), .FIFO_DEPTH(4)) u_dut3 (
        .CK(CK), .reset(reset), .start(start3), .dut_in(dut_in3), .dut_out(dut_out3),
        .busy(busy3), .done(done3), .rec_valid(rec_valid3), .rec_ready(rec_ready3),
        .rec_vec(rec_vec3), .rec_resp(rec_resp3), .rec_last(rec_last3),
        .ones_count(ones_count3)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    always @(posedge CK) cyc <= cyc + 1;

    always @(negedge CK) begin
        if (reset) begin
            if (rec_valid && rec_ready) recs.push_back({rec_vec, rec_resp, rec_last});
            if (done) begin
                done_cnt++;
                done_at = cyc;
            end
            if (done3) begin
                done3_cnt++;
                done3_at = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic par(input int v);
        logic [4:0] b;
        b = v[4:0];
        return ^b;
    endfunction

    task automatic run_start(input bit sel);
        if (!sel) recs.delete();
        @(negedge CK);
        if (sel) start3 = 1'b1;
        else start = 1'b1;
        @(posedge CK);
        #1;
        e0 = cyc;
        start  = 1'b0;
        start3 = 1'b0;
        check("start_busy", sel ? busy3 : busy, 1);
        check("start_dut_in", sel ? dut_in3 : dut_in, 0);
        check("start_ones_clr", sel ? ones_count3 : ones_count, 0);
    endtask

    task automatic wait_done(input bit sel, input int b, input int budget);
        int k;
        k = 0;
        while (((sel ? done3_cnt : done_cnt) == b) && (k < budget)) begin
            @(negedge CK);
            k++;
        end
        check("done_seen", (sel ? done3_cnt : done_cnt) != b, 1);
    endtask

    task automatic check_records();
        check("rec_count", recs.size(), 32);
        for (int i = 0; (i < recs.size()) && (i < 32); i++) begin
            check($sformatf("rec_vec[%0d]", i), recs[i][6:2], i);
            check($sformatf("rec_resp[%0d]", i), recs[i][1], par(i));
            check($sformatf("rec_last[%0d]", i), recs[i][0], (i == 31));
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        start3     = 1'b0;
        rec_ready  = 1'b1;
        rec_ready3 = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge CK);
        check("rst_dut_in", dut_in, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rec_valid", rec_valid, 0);
        check("rst_rec_fields", {rec_vec, rec_resp, rec_last}, 0);
        check("rst_ones", ones_count, 0);
        reset = 1'b1;

        // Parity circuit, consumer always ready.
        base = done_cnt;
        run_start(0);
        @(posedge CK);
        @(posedge CK);
        #1;
        check("first_rec_valid", rec_valid, 1);
        check("first_rec_vec", rec_vec, 0);
        check("first_rec_resp", rec_resp, 0);
        wait_done(0, base, 400);
        check("parity_done_time", done_at - e0, 66);
        check_records();
        check("parity_ones", ones_count, 16);
        @(posedge CK);
        #1;
        check("busy_fall", busy, 0);
        check("done_one_cycle", done, 0);
        repeat (3) @(posedge CK);
        #1;
        check("hold_dut_in", dut_in, 31);
        check("hold_ones", ones_count, 16);
        check("parity_done_pulses", done_cnt - base, 1);

        // AND circuit with a 3-cycle settle.
        base = done3_cnt;
        run_start(1);
        for (int j = 1; j <= 8; j++) begin
            @(posedge CK);
            #1;
            if (j == 3 || j == 4 || j == 7 || j == 8) check($sformatf("hold4_j%0d", j), dut_in3, j / 4);
        end
        wait_done(1, base, 600);
        check("and_done_time", done3_at - e0, 130);
        check("and_ones", ones_count3, 1);

        // Consumer stalled for the first 20 cycles.
        rec_ready = 1'b0;
        base = done_cnt;
        run_start(0);
        repeat (19) @(posedge CK);
        #1;
        check("stall_dut_in", dut_in, 4);
        check("stall_rec_valid", rec_valid, 1);
        check("stall_head_vec", rec_vec, 0);
        check("stall_busy", busy, 1);
        rec_ready = 1'b1;
        wait_done(0, base, 400);
        check_records();
        check("stall_ones", ones_count, 16);

        // Start pulses mid-run are ignored.
        base = done_cnt;
        run_start(0);
        repeat (10) @(posedge CK);
        #1 start = 1'b1;
        @(posedge CK);
        #1 start = 1'b0;
        repeat (19) @(posedge CK);
        #1 start = 1'b1;
        @(posedge CK);
        #1 start = 1'b0;
        wait_done(0, base, 400);
        check("restart_done_time", done_at - e0, 66);
        repeat (10) @(posedge CK);
        #1;
        check("restart_done_pulses", done_cnt - base, 1);
        check("restart_busy", busy, 0);
        check_records();

        // Reset asserted while vector 12 is on the bus.
        base = done_cnt;
        run_start(0);
        for (int k = 0; k < 100; k++) begin
            @(posedge CK);
            #1;
            if (dut_in == 5'd12) break;
        end
        check("reach_vec12", dut_in, 12);
        reset = 1'b0;
        #1;
        check("mid_rst_dut_in", dut_in, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_rec_valid", rec_valid, 0);
        check("mid_rst_rec_fields", {rec_vec, rec_resp, rec_last}, 0);
        check("mid_rst_ones", ones_count, 0);
        repeat (3) @(negedge CK);
        check("mid_rst_no_done", done_cnt, base);
        reset = 1'b1;
        run_start(0);
        wait_done(0, base, 400);
        check("post_rst_done_time", done_at - e0, 66);
        check_records();
        check("post_rst_ones", ones_count, 16);

        // Random consumer backpressure.
        base = done_cnt;
        run_start(0);
        for (int k = 0; (k < 2000) && (done_cnt == base); k++) begin
            @(posedge CK);
            #1 rec_ready = 1'($urandom_range(0, 1));
        end
        rec_ready = 1'b1;
        check("rand_done_seen", done_cnt - base, 1);
        check_records();
        check("rand_ones", ones_count, 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exhaustive_vector_sequencer.md
# exhaustive_vector_sequencer

Hardware stimulus scheduler for the small combinational/sequential benchmark circuits in the trojan-detection flow. It replaces per-vector bench sequencing: on `start` it walks every input vector 0 … 2^N_IN−1 onto the circuit under test, waits a programmable settle time, samples the single-bit response, and streams (vector, response) records through a small output FIFO with a valid/ready handshake. It also keeps a running count of 1-responses, so a run can be compared against a golden value without reading every record.

## Interface
- `N_IN`, 5, width of the circuit-under-test input vector (1..16).
- `SETTLE`, 1, cycles each vector is held before sampling (≥1).
- `FIFO_DEPTH`, 4, record FIFO entries (power of two, ≥2).

- `CK` input 1: single clock; all state changes on rising edge.
- `reset` input 1: asynchronous, active-low; low clears all state immediately.
- `start` input 1: begin a run; sampled only in IDLE.
- `dut_in` output N_IN: vector driven to the circuit under test (registered).
- `dut_out` input 1: response of the circuit under test.
- `busy` output 1: high from start acceptance until `done`.
- `done` output 1: one-cycle pulse at run end.
- `rec_valid` output 1: FIFO head record valid.
- `rec_ready` input 1: consumer accepts the head record.
- `rec_vec` output N_IN: vector of the head record.
- `rec_resp` output 1: response of the head record.
- `rec_last` output 1: head record belongs to vector 2^N_IN−1.
- `ones_count` output N_IN+1: number of 1-responses in the current or last run.

## Operation
- Reset values: every output is 0, state IDLE, FIFO empty, vector register 0, `ones_count` 0.
- States: IDLE, SETTLE, CAPTURE, DRAIN, DONE.
- IDLE → SETTLE when `start`=1:
  - vec ← 0; `dut_in` ← 0.
  - settle counter ← SETTLE−1.
  - `ones_count` ← 0; `busy` ← 1.
- SETTLE: decrement the counter; go to CAPTURE when the counter is 0.
- CAPTURE, FIFO not full:
  - Push {vec, `dut_out`, vec==all-ones}.
  - `ones_count` += `dut_out`.
  - If vec==all-ones, go to DRAIN.
  - Otherwise vec ← vec+1, `dut_in` updates, counter ← SETTLE−1, go to SETTLE.
- CAPTURE, FIFO full: stall in CAPTURE with `dut_in` held. `dut_out` is resampled every cycle, and only the value on the pushing edge is recorded.
- DRAIN: wait until the FIFO is empty, then go to DONE.
- DONE: `done`=1 for exactly one cycle, `busy`←0, then IDLE. `dut_in`, `ones_count` and vec hold their final values until the next start.
- `start` outside IDLE is ignored. It does not restart or extend the run.
- FIFO rules:
  - `rec_valid` = not empty; pop when `rec_valid` & `rec_ready`.
  - Records leave in push order; the head record fields are stable while `rec_valid` & !`rec_ready`.
  - Push is permitted only when count < FIFO_DEPTH. A same-cycle pop does not free space for a push on a full FIFO.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leaves the count unchanged.
- Width rules: vec increments modulo 2^N_IN, and the run ends before the wrap. `ones_count` cannot overflow (max 2^N_IN).
- `reset` low mid-run: immediate return to reset values. FIFO contents are discarded, and no `done` pulse is generated.

## Timing
- Start latency: `start` sampled at edge E0; `dut_in`=0 and `busy`=1 from E0.
- Per vector: SETTLE+1 cycles when unstalled.
- Each FIFO-full cycle in CAPTURE adds one cycle to the run.
- Record visibility: a record pushed at edge E is visible on `rec_*` from E at the earliest (when the FIFO was empty).
- Run length with `rec_ready` tied high: the final push happens at E0+2^N_IN·(SETTLE+1). `done` is high in the cycle after edge E0+2^N_IN·(SETTLE+1)+2, and `busy` falls on the following edge.

## Test plan
- Parity circuit model (`dut_out` = XOR of `dut_in`), N_IN=5, SETTLE=1, `rec_ready`=1:
  - 32 records arrive, vec 0..31 in order, `rec_resp` = parity.
  - `rec_last` is set only on vec 31.
  - `ones_count`=16; `done` after edge E0+66.
- SETTLE=3, AND-of-all-bits model:
  - `dut_in` holds each value 4 cycles.
  - `ones_count`=1; `done` after edge E0+130.
- `rec_ready`=0 for the first 20 cycles:
  - FIFO fills with vec 0..3 and the sequencer stalls with `dut_in`=4.
  - After `rec_ready`=1, all 32 records arrive in order with none lost or duplicated.
- Pulse `start` at cycles 10 and 30 during a run: both are ignored; one run, one `done` pulse.
- Assert `reset` low mid-run at vec 12:
  - All outputs read 0 immediately and `rec_valid`=0.
  - A new `start` restarts from vec 0 and completes normally.
- Random `rec_ready` (50%) with the parity model: the record stream and `ones_count`=16 match the first scenario.
